// File: rtl/vga_fb_arbiter_if.sv
// Bundle of the scan-out, writer and frame-buffer RAM signals around the
// arbiter. The slave modport is the arbiter's view. The master modport is
// the view of the surrounding system (VGA path, game logic and RAM).
interface vga_fb_arbiter_if #(
  parameter int AW         = 17,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic [LW-1:0] fifo_level;
  logic          starve;

  modport slave (
    input  disp_req, disp_addr, wr_req, wr_addr, wr_data, mem_rdata,
    output disp_data, disp_valid, wr_ready, mem_addr, mem_wdata, mem_we,
           fifo_level, starve
  );

  modport master (
    output disp_req, disp_addr, wr_req, wr_addr, wr_data, mem_rdata,
    input  disp_data, disp_valid, wr_ready, mem_addr, mem_wdata, mem_we,
           fifo_level, starve
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter. Scan-out reads always take the single RAM port.
// Game writes are queued in a small FIFO and drain on cycles with no display
// read. A starvation flag reports when the writer has been blocked for too long.
module vga_fb_arbiter #(
  parameter int AW         = 17,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 800
) (
  input logic                clk,
  input logic                reset,
  vga_fb_arbiter_if.slave    bus
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} port_state_t;

  port_state_t state_q, state_d;

  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          fifo_empty;
  logic          wr_ready;
  logic          push, pop;

  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [RD_LAT:0] vpipe;
  logic [DW-1:0] disp_data_q;
  logic          disp_valid_q;
  logic [CW-1:0] starve_cnt;

  assign fifo_empty = (level == '0);
  assign wr_ready   = (level != LW'(FIFO_DEPTH));
  assign push       = bus.wr_req && wr_ready;

  // Choose the next port owner: a display read always wins, otherwise drain one FIFO entry.
  always_comb begin
    state_d = IDLE;
    pop     = 1'b0;
    if (bus.disp_req) begin
      state_d = READ;
    end else if (!fifo_empty) begin
      state_d = WRITE;
      pop     = 1'b1;
    end
  end

  // Port state and registered RAM address/data, loaded from the decision above.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_d)
        READ: begin
          mem_addr_q <= bus.disp_addr;
        end
        WRITE: begin
          mem_addr_q  <= fifo_addr[rd_ptr];
          mem_wdata_q <= fifo_data[rd_ptr];
        end
        default: begin
        end
      endcase
    end
  end

  // FIFO storage needs no reset; only pointers and level define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.wr_addr;
      fifo_data[wr_ptr] <= bus.wr_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Track outstanding reads so each request returns exactly RD_LAT+2 cycles later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vpipe        <= '0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      vpipe        <= {vpipe[RD_LAT-1:0], bus.disp_req};
      disp_valid_q <= vpipe[RD_LAT];
      if (vpipe[RD_LAT]) disp_data_q <= bus.mem_rdata;
    end
  end

  // Count cycles the writer is blocked by display reads; saturates at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (bus.disp_req && (starve_cnt < CW'(STARVE_LIM))) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_we     = (state_q == WRITE);
  assign bus.disp_data  = disp_data_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.wr_ready   = wr_ready;
  assign bus.fifo_level = level;
  assign bus.starve     = (starve_cnt >= CW'(STARVE_LIM));
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter. Stimulus pushes the expected read data
// (with its due cycle) and the expected RAM writes into queues. A negedge
// monitor pops them whenever the DUT shows disp_valid or mem_we.
module tb_vga_fb_arbiter;
  localparam int AW     = 17;
  localparam int DW     = 8;
  localparam int FD     = 4;
  localparam int RD_LAT = 1;
  localparam int SL     = 800;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_fb_arbiter_if #(.AW(AW), .DW(DW), .FIFO_DEPTH(FD)) bus ();

  vga_fb_arbiter #(
    .AW(AW), .DW(DW), .FIFO_DEPTH(FD), .RD_LAT(RD_LAT), .STARVE_LIM(SL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {logic [DW-1:0] data; int due;} rd_exp_t;
  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_exp_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int burst_lo = -1;
  int burst_hi = -1;
  int burst_we = 0;

  logic [DW-1:0] ram_mem [logic [AW-1:0]];

  always @(posedge clk) cyc <= cyc + 1;

  // Power-on contents of the frame buffer for addresses never written.
  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // RAM model: one-cycle synchronous read that returns the old data on a same-edge write.
  always @(posedge clk) begin : ram_model
    logic [DW-1:0] r;
    r = ram_mem.exists(bus.mem_addr) ? ram_mem[bus.mem_addr] : pattern(bus.mem_addr);
    if (bus.mem_we) ram_mem[bus.mem_addr] = bus.mem_wdata;
    bus.mem_rdata <= r;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every disp_valid and mem_we must match the head of its queue.
  always @(negedge clk) begin : monitor
    rd_exp_t re;
    wr_exp_t we;
    if (!reset) begin
      if (bus.disp_valid) begin
        if (rd_q.size() == 0) begin
          checkOutput("unexpected_disp_valid", 32'd1, 32'd0);
        end else begin
          re = rd_q.pop_front();
          checkOutput("disp_data", 32'(bus.disp_data), 32'(re.data));
          checkOutput("disp_valid_cycle", cyc, re.due);
        end
      end
      if (bus.mem_we) begin
        if (cyc >= burst_lo && cyc <= burst_hi) burst_we++;
        if (wr_q.size() == 0) begin
          checkOutput("unexpected_mem_we", 32'd1, 32'd0);
        end else begin
          we = wr_q.pop_front();
          checkOutput("mem_addr_wr", 32'(bus.mem_addr), 32'(we.addr));
          checkOutput("mem_wdata", 32'(bus.mem_wdata), 32'(we.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitCycle(input int t);
    @(negedge clk);
    while (cyc < t) @(negedge clk);
  endtask

  // Drive one display cycle; a request is due back RD_LAT+2 cycles later.
  task automatic applyStimulus(input logic dreq, input logic [AW-1:0] daddr,
                               input logic [DW-1:0] dexp);
    bus.disp_req  = dreq;
    bus.disp_addr = daddr;
    if (dreq) rd_q.push_back('{dexp, cyc + RD_LAT + 2});
    tick();
    bus.disp_req = 1'b0;
  endtask

  // Offer one write and hold it until accepted (bounded wait).
  task automatic pushWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    while (!bus.wr_ready && n < 3000) begin
      tick();
      n++;
    end
    if (!bus.wr_ready) begin
      checkOutput("wr_ready_timeout", 32'd0, 32'd1);
    end else begin
      wr_q.push_back('{a, d});
      tick();
    end
    bus.wr_req = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    checkOutput({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    checkOutput({tag, "_disp_valid"}, 32'(bus.disp_valid), 32'd0);
    checkOutput({tag, "_disp_data"}, 32'(bus.disp_data), 32'd0);
    checkOutput({tag, "_fifo_level"}, 32'(bus.fifo_level), 32'd0);
    checkOutput({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd1);
    checkOutput({tag, "_starve"}, 32'(bus.starve), 32'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int s;
    reset         = 1'b1;
    bus.disp_req  = 1'b0;
    bus.disp_addr = '0;
    bus.wr_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    ram_mem[17'h00123] = 8'hA5;

    @(negedge clk);
    checkResetOutputs("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle: nothing should move for 10 cycles.
    repeat (10) begin
      @(negedge clk);
      checkOutput("idle_mem_we", 32'(bus.mem_we), 32'd0);
      checkOutput("idle_wr_ready", 32'(bus.wr_ready), 32'd1);
      checkOutput("idle_fifo_level", 32'(bus.fifo_level), 32'd0);
      checkOutput("idle_disp_valid", 32'(bus.disp_valid), 32'd0);
    end
    tick();

    // Single read; RAM holds 0xA5 at 0x00123.
    applyStimulus(1'b1, 17'h00123, 8'hA5);
    @(negedge clk);
    checkOutput("read_mem_addr", 32'(bus.mem_addr), 32'h00123);
    checkOutput("read_mem_we", 32'(bus.mem_we), 32'd0);
    repeat (6) tick();

    // Three writes with an idle display drain in push order.
    pushWrite(17'h00010, 8'h11);
    pushWrite(17'h00020, 8'h22);
    pushWrite(17'h00030, 8'h33);
    repeat (6) tick();
    checkOutput("writes_drained_level", 32'(bus.fifo_level), 32'd0);

    // Read of an address still pending in the FIFO returns the old contents (0x40^0x5A).
    pushWrite(17'h00040, 8'h44);
    applyStimulus(1'b1, 17'h00040, 8'h1A);
    repeat (6) tick();

    // Write in one port cycle, read the same address in the next: new data.
    pushWrite(17'h00050, 8'h55);
    applyStimulus(1'b0, 17'h0, 8'h0);
    applyStimulus(1'b1, 17'h00050, 8'h55);
    repeat (6) tick();

    // Full FIFO under 1000 cycles of display reads.
    s = cyc;
    burst_lo = s + 1;
    burst_hi = s + 1000;
    fork
      begin
        for (int i = 0; i < 1000; i++)
          applyStimulus(1'b1, 17'h01000 + 17'(i), pattern(17'h01000 + 17'(i)));
      end
      begin
        for (int j = 0; j < 6; j++)
          pushWrite(17'h00300 + 17'(j), 8'h80 + 8'(j));
      end
      begin
        waitCycle(s + 10);
        checkOutput("full_fifo_level", 32'(bus.fifo_level), 32'd4);
        checkOutput("full_wr_ready", 32'(bus.wr_ready), 32'd0);
        // Level first non-zero in cycle s+1, so 800 blocked edges complete by cycle s+801.
        waitCycle(s + 800);
        checkOutput("starve_before_limit", 32'(bus.starve), 32'd0);
        waitCycle(s + 801);
        checkOutput("starve_at_limit", 32'(bus.starve), 32'd1);
        waitCycle(s + 1000);
        checkOutput("starve_held", 32'(bus.starve), 32'd1);
        waitCycle(s + 1001);
        checkOutput("starve_cleared_on_write", 32'(bus.starve), 32'd0);
        checkOutput("first_write_after_burst", 32'(bus.mem_we), 32'd1);
      end
    join
    repeat (20) tick();
    checkOutput("burst_no_mem_we", burst_we, 0);
    checkOutput("burst_drained_level", 32'(bus.fifo_level), 32'd0);
    checkOutput("burst_starve_low", 32'(bus.starve), 32'd0);

    // Interleaved: reads every other cycle, writer held busy.
    fork
      begin
        for (int i = 0; i < 40; i++)
          applyStimulus((i % 2) == 0, 17'h00600 + 17'(i), pattern(17'h00600 + 17'(i)));
      end
      begin
        for (int k = 0; k < 12; k++)
          pushWrite(17'h00500 + 17'(k), 8'hC0 + 8'(k));
      end
    join
    repeat (20) tick();
    checkOutput("interleave_level", 32'(bus.fifo_level), 32'd0);

    // Reset mid-operation with three queued writes and reads in flight.
    fork
      begin
        for (int i = 0; i < 3; i++)
          applyStimulus(1'b1, 17'h00700 + 17'(i), pattern(17'h00700 + 17'(i)));
      end
      begin
        for (int k = 0; k < 3; k++)
          pushWrite(17'h00800 + 17'(k), 8'hE0 + 8'(k));
      end
    join
    checkOutput("pre_reset_level", 32'(bus.fifo_level), 32'd3);
    #2;
    reset = 1'b1;
    rd_q.delete();
    wr_q.delete();
    #1;
    checkResetOutputs("midreset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) tick();
    checkOutput("post_reset_level", 32'(bus.fifo_level), 32'd0);
    checkOutput("post_reset_wr_ready", 32'(bus.wr_ready), 32'd1);

    checkOutput("rd_queue_empty", rd_q.size(), 0);
    checkOutput("wr_queue_empty", wr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
